aes128_sbox_scheduler: RTL and testbench
========================================

# aes128_sbox_scheduler

Sequencer for the shared masked S-box pipeline (tower-field inversion built from the GF(2^4)/GF(2^2) sub-blocks) in the three-stage AES-128 core. It issues the 16 state bytes and 4 key-schedule bytes of every round into the single S-box instance, one per cycle. It stalls issue whenever fresh mask randomness is unavailable and tracks in-flight bytes so each S-box output is written back to the correct register. After each round's last write-back it strobes the linear layer (ShiftRows/MixColumns/AddRoundKey), counts rounds 1..10, and signals completion.

## Interface
- PIPE_STAGES, default 3: S-box pipeline latency in cycles (issue to output); legal range 1..7.
- NUM_ROUNDS, default 10: AES-128 round count.
- in_clock  input  1  single clock; all state updates on rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_start  input  1  start an encryption; sampled only in IDLE.
- in_rand_ok  input  1  fresh S-box randomness available this cycle; gates issue.
- out_ready  output  1  high in IDLE (block accepts in_start).
- out_sbox_valid  output  1  a byte enters the S-box this cycle.
- out_sbox_sel  output  5  source byte index: 16..19 = key bytes, 0..15 = state bytes.
- out_wb_valid  output  1  S-box output valid this cycle; write to register out_wb_sel.
- out_wb_sel  output  5  destination index, same encoding as out_sbox_sel.
- out_round  output  4  current round 1..NUM_ROUNDS; 0 in IDLE.
- out_round_end  output  1  one-cycle strobe: apply linear layer for out_round.
- out_last_round  output  1  qualifies out_round_end: skip MixColumns (out_round == NUM_ROUNDS).
- out_done  output  1  one-cycle pulse: ciphertext complete.

## Operation
- States: IDLE, ISSUE, DRAIN, LINEAR.
- IDLE: out_ready=1. in_start=1 -> ISSUE, round=1, issue count=0. in_start is ignored in all other states.
- ISSUE: if in_rand_ok=1, assert out_sbox_valid, out_sbox_sel=order[count], count++.
  - Order: 16,17,18,19, then 0,1,...,15. Key bytes go first so the key schedule finishes before AddRoundKey.
  - If in_rand_ok=0, there is no issue, count holds, and in-flight bytes keep advancing.
  - After the 20th issue (count 19) -> DRAIN.
- In-flight tracking: PIPE_STAGES-deep shift register of {valid, sel}. out_wb_valid/out_wb_sel are the last stage. Every issued byte is written back exactly PIPE_STAGES cycles after issue, stalls or not.
- DRAIN: wait until no issued byte remains un-written-back. The cycle after the last write-back -> LINEAR.
- LINEAR (one cycle): out_round_end=1, out_last_round=(round==NUM_ROUNDS).
  - If round==NUM_ROUNDS: out_done=1 and the next state is IDLE, with round reset to 0.
  - Otherwise: round++, count=0, next state ISSUE.
- No byte is ever issued in DRAIN or LINEAR. out_wb_valid is never high in LINEAR.
- Round counter is 4 bits and saturates by construction; it never wraps.

## Timing
- Reset: state=IDLE, count=0, round=0, shift register cleared. Outputs: out_ready=1, all other outputs 0 (sel fields 0). Reset mid-operation aborts immediately, and pending write-backs are discarded.
- All outputs are registered-state decodes with no combinational path from in_start. out_sbox_valid depends combinationally on in_rand_ok in ISSUE.
- With in_rand_ok held at 1, start sampled at edge of cycle 0, and PIPE_STAGES=3:
  - ISSUE occupies cycles 1..20 and write-backs occur in cycles 4..23.
  - DRAIN occupies cycles 21..23 and LINEAR is cycle 24.
  - Round r LINEAR is at cycle 24r; out_done is at cycle 240; out_ready is back in cycle 241.
- General round length is 20 + S + PIPE_STAGES + 1 cycles, where S = cycles with in_rand_ok=0 during ISSUE.
- in_start=1 in the LINEAR/done cycle is ignored. A start is accepted only in a cycle where out_ready=1.

## Test plan
- Reset then start, in_rand_ok=1: out_sbox_sel sequence is 16..19,0..15 in cycles 1..20. out_wb_sel shows the same sequence in cycles 4..23. out_round_end at cycles 24,48,...,240. out_last_round only at 240, together with out_done. out_round=10 there, and 0 in cycle 241.
- in_rand_ok=0 in cycles 3 and 10 of round 1: no issue in those cycles; sel in cycle 4 = 18; round-1 LINEAR at cycle 26; every write-back exactly 3 cycles after its issue.
- in_start pulsed in cycles 5 and 24 during a run: no effect. Second start in cycle 241 begins a new run with round=1.
- in_reset asserted in cycle 30 (round 2 ISSUE): in cycle 31 out_ready=1, out_round=0, out_wb_valid=0 even though 3 bytes were in flight.
- PIPE_STAGES=1 and PIPE_STAGES=7 builds: write-back lag equals the parameter, and the round period is 22 and 28 cycles respectively.
- Scoreboard check over a full run with random in_rand_ok (50%): exactly 200 issues and 200 write-backs, every index 0..19 written once per round, out_done exactly once.

Source files
------------

// File: rtl/aes128_sbox_scheduler.sv
// Issue sequencer for the shared masked S-box: feeds 4 key bytes then 16 state bytes
// per round, tracks in-flight bytes for write-back and strobes the linear layer.
module aes128_sbox_scheduler #(
    parameter int unsigned PIPE_STAGES = 3,
    parameter int unsigned NUM_ROUNDS  = 10
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_start,
    input  logic       in_rand_ok,
    output logic       out_ready,
    output logic       out_sbox_valid,
    output logic [4:0] out_sbox_sel,
    output logic       out_wb_valid,
    output logic [4:0] out_wb_sel,
    output logic [3:0] out_round,
    output logic       out_round_end,
    output logic       out_last_round,
    output logic       out_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, LINEAR} state_t;

    state_t                 state_q, state_d;
    logic [4:0]             count_q, count_d;
    logic [3:0]             round_q, round_d;
    logic [PIPE_STAGES-1:0] pipe_valid_q, pipe_valid_d;
    logic [4:0]             pipe_sel_q [PIPE_STAGES];
    logic [4:0]             pipe_sel_d [PIPE_STAGES];

    logic       issue;
    logic [4:0] issue_sel;
    logic       upstream_busy;
    logic       last_round;

    always_comb begin
        issue      = (state_q == ISSUE) && in_rand_ok;
        // Key bytes 16..19 first, then state bytes 0..15.
        issue_sel  = (count_q < 5'd4) ? count_q + 5'd16 : count_q - 5'd4;
        last_round = (round_q == 4'(NUM_ROUNDS));

        // The final stage is being written back this cycle, so only earlier stages keep DRAIN alive.
        upstream_busy = 1'b0;
        for (int unsigned i = 0; i + 1 < PIPE_STAGES; i++) begin
            upstream_busy = upstream_busy | pipe_valid_q[i];
        end

        pipe_valid_d    = '0;
        pipe_sel_d      = '{default: '0};
        pipe_valid_d[0] = issue;
        pipe_sel_d[0]   = issue ? issue_sel : '0;
        for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_sel_d[i]   = pipe_sel_q[i-1];
        end

        state_d = state_q;
        count_d = count_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (in_start) begin
                    state_d = ISSUE;
                    round_d = 4'd1;
                    count_d = '0;
                end
            end
            ISSUE: begin
                if (issue) begin
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd19) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!upstream_busy) state_d = LINEAR;
            end
            LINEAR: begin
                count_d = '0;
                if (last_round) begin
                    state_d = IDLE;
                    round_d = '0;
                end else begin
                    state_d = ISSUE;
                    round_d = round_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            round_q      <= '0;
            pipe_valid_q <= '0;
            for (int unsigned i = 0; i < PIPE_STAGES; i++) pipe_sel_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            round_q      <= round_d;
            pipe_valid_q <= pipe_valid_d;
            for (int unsigned i = 0; i < PIPE_STAGES; i++) pipe_sel_q[i] <= pipe_sel_d[i];
        end
    end

    assign out_ready      = (state_q == IDLE);
    assign out_sbox_valid = issue;
    assign out_sbox_sel   = issue ? issue_sel : '0;
    assign out_wb_valid   = pipe_valid_q[PIPE_STAGES-1];
    assign out_wb_sel     = pipe_sel_q[PIPE_STAGES-1];
    assign out_round      = round_q;
    assign out_round_end  = (state_q == LINEAR);
    assign out_last_round = (state_q == LINEAR) && last_round;
    assign out_done       = (state_q == LINEAR) && last_round;

endmodule

// File: tb/tb_aes128_sbox_scheduler.sv
// Scoreboard bench: stimulus pushes expected issue/write-back/round-end/done events,
// a negedge monitor pops and compares them; two extra builds check PIPE_STAGES 1 and 7.
module tb_aes128_sbox_scheduler;

    logic       clk = 1'b0;
    logic       in_reset = 1'b1, in_start = 1'b0, in_rand_ok = 1'b0;
    logic       out_ready, out_sbox_valid, out_wb_valid, out_round_end, out_last_round, out_done;
    logic [4:0] out_sbox_sel, out_wb_sel;
    logic [3:0] out_round;

    always #5 clk = ~clk;

    aes128_sbox_scheduler #(.PIPE_STAGES(3), .NUM_ROUNDS(10)) dut (
        .in_clock(clk), .in_reset(in_reset), .in_start(in_start), .in_rand_ok(in_rand_ok),
        .out_ready(out_ready), .out_sbox_valid(out_sbox_valid), .out_sbox_sel(out_sbox_sel),
        .out_wb_valid(out_wb_valid), .out_wb_sel(out_wb_sel), .out_round(out_round),
        .out_round_end(out_round_end), .out_last_round(out_last_round), .out_done(out_done)
    );

    logic       aux_reset = 1'b1, aux_start = 1'b0;
    logic [1:0] aux_ready, aux_sv, aux_wv, aux_end, aux_last, aux_done;
    logic [4:0] aux_sel [2];
    logic [4:0] aux_wsel [2];
    logic [3:0] aux_round [2];

    aes128_sbox_scheduler #(.PIPE_STAGES(1), .NUM_ROUNDS(10)) dut_p1 (
        .in_clock(clk), .in_reset(aux_reset), .in_start(aux_start), .in_rand_ok(1'b1),
        .out_ready(aux_ready[0]), .out_sbox_valid(aux_sv[0]), .out_sbox_sel(aux_sel[0]),
        .out_wb_valid(aux_wv[0]), .out_wb_sel(aux_wsel[0]), .out_round(aux_round[0]),
        .out_round_end(aux_end[0]), .out_last_round(aux_last[0]), .out_done(aux_done[0])
    );

    aes128_sbox_scheduler #(.PIPE_STAGES(7), .NUM_ROUNDS(10)) dut_p7 (
        .in_clock(clk), .in_reset(aux_reset), .in_start(aux_start), .in_rand_ok(1'b1),
        .out_ready(aux_ready[1]), .out_sbox_valid(aux_sv[1]), .out_sbox_sel(aux_sel[1]),
        .out_wb_valid(aux_wv[1]), .out_wb_sel(aux_wsel[1]), .out_round(aux_round[1]),
        .out_round_end(aux_end[1]), .out_last_round(aux_last[1]), .out_done(aux_done[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: DUT output with no expected event", name, cyc);
    endtask

    typedef struct { int cyc; int val; int aux; } ev_t;
    ev_t q_iss[$], q_wb[$], q_end[$], q_done[$];

    always @(negedge clk) begin
        ev_t e;
        if (out_sbox_valid === 1'b1) begin
            if (q_iss.size() == 0) unexpected("issue");
            else begin
                e = q_iss.pop_front();
                chk("issue_cycle", cyc, e.cyc);
                chk("issue_sel", int'(out_sbox_sel), e.val);
            end
        end
        if (out_wb_valid === 1'b1) begin
            if (q_wb.size() == 0) unexpected("wb");
            else begin
                e = q_wb.pop_front();
                chk("wb_cycle", cyc, e.cyc);
                chk("wb_sel", int'(out_wb_sel), e.val);
            end
        end
        if (out_round_end === 1'b1) begin
            if (q_end.size() == 0) unexpected("round_end");
            else begin
                e = q_end.pop_front();
                chk("end_cycle", cyc, e.cyc);
                chk("end_round", int'(out_round), e.val);
                chk("end_last", int'(out_last_round), e.aux);
            end
        end
        if (out_done === 1'b1) begin
            if (q_done.size() == 0) unexpected("done");
            else begin
                e = q_done.pop_front();
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Side builds: write-back lag and round period per PIPE_STAGES.
    int aux_ic [2][256];
    int aux_is [2][256];
    int aux_wr [2] = '{0, 0};
    int aux_rd [2] = '{0, 0};
    int aux_prev [2] = '{0, 0};
    int aux_dones [2] = '{0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (aux_sv[k] === 1'b1 && aux_wr[k] < 256) begin
                aux_ic[k][aux_wr[k]] = cyc;
                aux_is[k][aux_wr[k]] = int'(aux_sel[k]);
                aux_wr[k]++;
            end
            if (aux_wv[k] === 1'b1) begin
                if (aux_rd[k] >= aux_wr[k]) unexpected("aux_wb");
                else begin
                    chk("aux_wb_lag", cyc - aux_ic[k][aux_rd[k]], (k == 0) ? 1 : 7);
                    chk("aux_wb_sel", int'(aux_wsel[k]), aux_is[k][aux_rd[k]]);
                    aux_rd[k]++;
                end
            end
            if (aux_end[k] === 1'b1) begin
                chk("aux_period", cyc - aux_prev[k], (k == 0) ? 22 : 28);
                aux_prev[k] = cyc;
            end
            if (aux_done[k] === 1'b1) aux_dones[k]++;
        end
    end

    bit rand_pat [1024];

    function automatic int ord(input int c);
        return (c < 4) ? c + 16 : c - 4;
    endfunction

    // cutoff >= 0: assert reset in that cycle and expect nothing afterwards.
    task automatic run(input int cutoff, input int pulse_a, input int pulse_b,
                       input int sel_rel, input int sel_val, input int end_rel);
        int   c0, t, cnt, lin, done_rel, last;
        ev_t  e;
        c0 = cyc;
        t  = 1;
        done_rel = 0;
        for (int r = 1; r <= 10; r++) begin
            cnt = 0;
            while (cnt < 20 && t < 1000) begin
                if (rand_pat[t]) begin
                    if (cutoff < 0 || t <= cutoff) begin
                        e = '{c0 + t, ord(cnt), 0};
                        q_iss.push_back(e);
                    end
                    if (cutoff < 0 || t + 3 <= cutoff) begin
                        e = '{c0 + t + 3, ord(cnt), 0};
                        q_wb.push_back(e);
                    end
                    cnt++;
                end
                t++;
            end
            lin = t + 3;
            if (cutoff < 0 || lin <= cutoff) begin
                e = '{c0 + lin, r, (r == 10) ? 1 : 0};
                q_end.push_back(e);
                if (r == 10) begin
                    e = '{c0 + lin, 0, 0};
                    q_done.push_back(e);
                end
            end
            done_rel = lin;
            t = lin + 1;
        end
        last = (cutoff >= 0) ? cutoff : done_rel;
        for (int rel = 0; rel <= last; rel++) begin
            in_start   = (rel == 0) || (rel == pulse_a) || (rel == pulse_b);
            in_rand_ok = rand_pat[rel];
            in_reset   = (rel == cutoff);
            #1;
            if (rel == sel_rel) chk("sel_probe", int'(out_sbox_sel), sel_val);
            if (rel == end_rel) chk("end_probe", int'(out_round_end), 1);
            @(posedge clk);
            #1;
        end
        in_start   = 1'b0;
        in_reset   = 1'b0;
        in_rand_ok = 1'b0;
        #1;
        chk("post_ready", int'(out_ready), 1);
        chk("post_round", int'(out_round), 0);
        if (cutoff >= 0) chk("post_reset_wb", int'(out_wb_valid), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(out_ready), 1);
        chk("rst_sbox_valid", int'(out_sbox_valid), 0);
        chk("rst_sbox_sel", int'(out_sbox_sel), 0);
        chk("rst_wb_valid", int'(out_wb_valid), 0);
        chk("rst_wb_sel", int'(out_wb_sel), 0);
        chk("rst_round", int'(out_round), 0);
        chk("rst_round_end", int'(out_round_end), 0);
        chk("rst_last", int'(out_last_round), 0);
        chk("rst_done", int'(out_done), 0);
        in_reset  = 1'b0;
        aux_reset = 1'b0;
        aux_start = 1'b1;
        aux_prev[0] = cyc;
        aux_prev[1] = cyc;
        @(posedge clk);
        #1;
        aux_start = 1'b0;

        // Steady randomness, stray starts in ISSUE and LINEAR.
        foreach (rand_pat[i]) rand_pat[i] = 1'b1;
        run(-1, 5, 24, 4, 19, 24);

        // Restart in the cycle after done; stalls in cycles 3 and 10.
        rand_pat[3]  = 1'b0;
        rand_pat[10] = 1'b0;
        run(-1, -1, -1, 4, 18, 26);

        // Reset during round-2 ISSUE with three bytes in flight.
        foreach (rand_pat[i]) rand_pat[i] = 1'b1;
        run(30, -1, -1, -1, 0, 24);
        repeat (2) @(posedge clk);
        #1;

        foreach (rand_pat[i]) rand_pat[i] = 1'($urandom_range(0, 1));
        rand_pat[0] = 1'b1;
        run(-1, -1, -1, -1, 0, -1);

        repeat (5) @(posedge clk);
        #1;
        chk("left_issue", q_iss.size(), 0);
        chk("left_wb", q_wb.size(), 0);
        chk("left_end", q_end.size(), 0);
        chk("left_done", q_done.size(), 0);
        chk("p1_issues", aux_wr[0], 200);
        chk("p1_wbs", aux_rd[0], 200);
        chk("p1_done", aux_dones[0], 1);
        chk("p7_issues", aux_wr[1], 200);
        chk("p7_wbs", aux_rd[1], 200);
        chk("p7_done", aux_dones[1], 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
